dummy_accelerator_dp: RTL and testbench

Datapath stage of the dummy accelerator. It consumes `ctl_pipe_en`, `imm_buff_en` and `imm_buff_sel` from the accelerator control unit. It holds the immediate buffer and a variable-depth result pipeline that returns each operand, plus its effective latency, after an immediate-selected number of cycles. It sits between the core issue interface (valid/ready in) and the core writeback interface (valid/ready out).

---
 rtl/dummy_accelerator_dp.sv | 132 +++++++++++++
 tb/tb_dummy_accelerator_dp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_dp.sv
// Datapath stage of the dummy accelerator: immediate buffer plus a variable-depth
// result pipeline that returns data + effective latency after that many cycles.
module dummy_accelerator_dp #(
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned TagWidth   = 4,
   parameter int unsigned CtlWidth   = 8,
   parameter int unsigned MaxLatency = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [CtlWidth-1:0]  imm_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic [TagWidth-1:0]  tag_i,
   input  logic                 ctl_pipe_en_i,
   input  logic                 imm_buff_en_i,
   input  logic                 imm_buff_sel_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic [TagWidth-1:0]  tag_o
);
   localparam int unsigned LatWidth = $clog2(MaxLatency + 1);

   // Handshake: an op transfers on an edge where valid_i && ready_o (in) or
   // valid_o && ready_i (out); valid never waits on ready within this block.
   logic [MaxLatency-1:0] v_q, v_d;
   logic [DataWidth-1:0]  data_q [MaxLatency];
   logic [DataWidth-1:0]  data_d [MaxLatency];
   logic [TagWidth-1:0]   tag_q  [MaxLatency];
   logic [TagWidth-1:0]   tag_d  [MaxLatency];
   logic [CtlWidth-1:0]   imm_q, imm_d;
   logic [LatWidth-1:0]   lat_q, lat_d;

   logic [CtlWidth-1:0]   imm_sel;
   logic [LatWidth-1:0]   lat_eff;
   logic [LatWidth-1:0]   sel_lat;
   logic                  empty;
   logic                  bypass;
   logic                  adv;
   logic                  accept;
   logic                  out_v;
   logic [DataWidth-1:0]  out_data;
   logic [TagWidth-1:0]   out_tag;

   always_comb begin
      imm_sel = imm_buff_sel_i ? imm_q : imm_i;
      if (imm_sel > CtlWidth'(MaxLatency)) begin
         lat_eff = LatWidth'(MaxLatency);
      end else begin
         lat_eff = LatWidth'(imm_sel);
      end
   end

   assign empty  = ~|v_q;
   assign bypass = (lat_eff == '0) && empty;

   // In-flight ops drain from the stage of their own latency; an empty pipe
   // looks at the stage the incoming latency would use.
   always_comb begin
      out_v    = 1'b0;
      out_data = '0;
      out_tag  = '0;
      sel_lat  = empty ? lat_eff : lat_q;
      for (int k = 0; k < MaxLatency; k++) begin
         if (sel_lat == LatWidth'(k + 1)) begin
            out_v    = v_q[k];
            out_data = data_q[k];
            out_tag  = tag_q[k];
         end
      end
      if (bypass) begin
         out_v    = valid_i;
         out_data = data_i;
         out_tag  = tag_i;
      end
   end

   assign valid_o = out_v;
   assign data_o  = out_v ? out_data : '0;
   assign tag_o   = out_v ? out_tag : '0;

   assign adv     = ctl_pipe_en_i && !(out_v && !ready_i);
   assign ready_o = bypass ? ready_i
                           : (lat_eff != '0) && adv && (empty || lat_eff == lat_q);
   assign accept  = valid_i && ready_o && (lat_eff != '0);

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      tag_d  = tag_q;
      imm_d  = imm_q;
      lat_d  = lat_q;
      if (imm_buff_en_i) begin
         imm_d = imm_i;
      end
      if (adv) begin
         for (int k = MaxLatency - 1; k > 0; k--) begin
            if (LatWidth'(k) < lat_q) begin
               v_d[k]    = v_q[k-1];
               data_d[k] = data_q[k-1];
               tag_d[k]  = tag_q[k-1];
            end else begin
               v_d[k] = 1'b0;
            end
         end
         v_d[0]    = accept;
         data_d[0] = data_i + DataWidth'(lat_eff);
         tag_d[0]  = tag_i;
         if (accept) begin
            lat_d = lat_eff;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         v_q   <= '0;
         imm_q <= '0;
         lat_q <= '0;
      end else begin
         v_q   <= v_d;
         imm_q <= imm_d;
         lat_q <= lat_d;
      end
      data_q <= data_d;
      tag_q  <= tag_d;
   end

endmodule

// File: tb/tb_dummy_accelerator_dp.sv
// Directed bench for dummy_accelerator_dp: bypass, pipelining, backpressure,
// stalls, saturation, latency change, flush and synchronous reset.
module tb_dummy_accelerator_dp;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  imm_i;
   logic [63:0] data_i;
   logic [3:0]  tag_i;
   logic        ctl_pipe_en_i;
   logic        imm_buff_en_i;
   logic        imm_buff_sel_i;
   logic        valid_o;
   logic        ready_i;
   logic [63:0] data_o;
   logic [3:0]  tag_o;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   dummy_accelerator_dp dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .imm_i          (imm_i),
      .data_i         (data_i),
      .tag_i          (tag_i),
      .ctl_pipe_en_i  (ctl_pipe_en_i),
      .imm_buff_en_i  (imm_buff_en_i),
      .imm_buff_sel_i (imm_buff_sel_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .data_o         (data_o),
      .tag_o          (tag_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] imm, input logic [63:0] d,
                        input logic [3:0] t);
      valid_i = v;
      imm_i   = imm;
      data_i  = d;
      tag_i   = t;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; ctl_pipe_en_i = 1'b1; imm_buff_en_i = 1'b0;
      imm_buff_sel_i = 1'b0; ready_i = 1'b1;
      drive(1'b0, 8'd0, 64'h0, 4'h0);
      tick(); tick();

      // Reset state
      rst_ni = 1'b1; imm_i = 8'd1; #1;
      chk("rst_valid", valid_o, 0); chk("rst_data", data_o, 0);
      chk("rst_tag", tag_o, 0); chk("rst_ready", ready_o, 1);

      // Bypass with L = 0
      drive(1'b1, 8'd0, 64'h10, 4'd5); #1;
      chk("byp_valid", valid_o, 1); chk("byp_data", data_o, 64'h10);
      chk("byp_tag", tag_o, 5); chk("byp_ready", ready_o, 1);
      tick();
      drive(1'b0, 8'd1, 64'h0, 4'h0); #1;
      chk("byp_nostate_valid", valid_o, 0); chk("byp_nostate_ready", ready_o, 1);

      // Back-to-back with L = 3
      drive(1'b1, 8'd3, 64'h100, 4'd1); #1; chk("b2b_ready0", ready_o, 1); tick();
      drive(1'b1, 8'd3, 64'h200, 4'd2); #1; chk("b2b_ready1", ready_o, 1); tick();
      drive(1'b1, 8'd3, 64'h300, 4'd3); #1; chk("b2b_early_valid", valid_o, 0); tick();
      drive(1'b0, 8'd3, 64'h0, 4'h0); #1;
      chk("b2b_v1", valid_o, 1); chk("b2b_d1", data_o, 64'h103); chk("b2b_t1", tag_o, 1);
      tick(); #1;
      chk("b2b_v2", valid_o, 1); chk("b2b_d2", data_o, 64'h203); chk("b2b_t2", tag_o, 2);
      tick(); #1;
      chk("b2b_v3", valid_o, 1); chk("b2b_d3", data_o, 64'h303); chk("b2b_t3", tag_o, 3);
      tick(); #1;
      chk("b2b_drained", valid_o, 0);

      // Backpressure with L = 2
      drive(1'b1, 8'd2, 64'hA0, 4'd4); #1; tick();
      drive(1'b1, 8'd2, 64'hB0, 4'd5); #1; chk("bp_ready_pre", ready_o, 1); tick();
      drive(1'b1, 8'd2, 64'hC0, 4'd6); ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_ready", ready_o, 0); chk("bp_valid", valid_o, 1);
         chk("bp_data", data_o, 64'hA2); chk("bp_tag", tag_o, 4);
         tick();
      end
      ready_i = 1'b1; #1;
      chk("bp_rel_ready", ready_o, 1); chk("bp_rel_data", data_o, 64'hA2); tick();
      drive(1'b0, 8'd2, 64'h0, 4'h0); #1;
      chk("bp_d2", data_o, 64'hB2); chk("bp_t2", tag_o, 5); tick(); #1;
      chk("bp_d3", data_o, 64'hC2); chk("bp_t3", tag_o, 6); tick(); #1;
      chk("bp_drained", valid_o, 0);

      // Control-unit stall
      drive(1'b1, 8'd2, 64'hC00, 4'd3); #1; tick();
      drive(1'b1, 8'd2, 64'hD00, 4'd4); ctl_pipe_en_i = 1'b0; #1;
      chk("stall_ready", ready_o, 0); tick(); tick();
      drive(1'b0, 8'd2, 64'h0, 4'h0); ctl_pipe_en_i = 1'b1; #1;
      chk("stall_frozen_valid", valid_o, 0); tick(); #1;
      chk("stall_out_data", data_o, 64'hC02); ctl_pipe_en_i = 1'b0; tick(); #1;
      chk("stall_hold_valid", valid_o, 1); chk("stall_hold_data", data_o, 64'hC02);
      chk("stall_hold_tag", tag_o, 3);
      ctl_pipe_en_i = 1'b1; tick(); #1;
      chk("stall_drained", valid_o, 0);

      // Saturation through the buffered immediate
      imm_buff_en_i = 1'b1; drive(1'b0, 8'd20, 64'h0, 4'h0); tick(); imm_buff_en_i = 1'b0;
      imm_buff_sel_i = 1'b1; drive(1'b1, 8'd0, 64'h1000, 4'd7); #1;
      chk("sat_ready", ready_o, 1); tick();
      drive(1'b0, 8'd0, 64'h0, 4'h0);
      for (int i = 1; i < 8; i++) begin
         #1; chk("sat_wait_valid", valid_o, 0); tick();
      end
      #1;
      chk("sat_valid", valid_o, 1); chk("sat_data", data_o, 64'h1008); chk("sat_tag", tag_o, 7);
      tick(); #1;
      chk("sat_drained", valid_o, 0);

      // Buffer load while selecting imm_i
      imm_buff_sel_i = 1'b0; imm_buff_en_i = 1'b1; drive(1'b1, 8'd1, 64'h2000, 4'd8); #1;
      chk("sel0_ready", ready_o, 1); tick();
      imm_buff_en_i = 1'b0; drive(1'b0, 8'd0, 64'h0, 4'h0); #1;
      chk("sel0_data", data_o, 64'h2001); chk("sel0_tag", tag_o, 8); tick();
      imm_buff_sel_i = 1'b1; drive(1'b1, 8'd0, 64'h3000, 4'd9); #1;
      chk("immq1_nobypass", valid_o, 0); tick();
      drive(1'b0, 8'd0, 64'h0, 4'h0); #1;
      chk("immq1_data", data_o, 64'h3001); tick();
      imm_buff_sel_i = 1'b0;

      // Latency change with an op in flight
      drive(1'b1, 8'd4, 64'h400, 4'd9); #1; chk("lc_first_ready", ready_o, 1); tick();
      drive(1'b1, 8'd2, 64'h500, 4'd10);
      for (int i = 1; i < 4; i++) begin
         #1; chk("lc_ready_wait", ready_o, 0); chk("lc_valid_wait", valid_o, 0); tick();
      end
      #1;
      chk("lc_ready_busy", ready_o, 0); chk("lc_first_data", data_o, 64'h404);
      chk("lc_first_tag", tag_o, 9); tick(); #1;
      chk("lc_ready_empty", ready_o, 1); tick();
      drive(1'b0, 8'd2, 64'h0, 4'h0); #1;
      chk("lc_second_wait", valid_o, 0); tick(); #1;
      chk("lc_second_data", data_o, 64'h502); chk("lc_second_tag", tag_o, 10); tick();

      // Flush with two ops in flight and a nonzero buffered immediate
      imm_buff_en_i = 1'b1; drive(1'b0, 8'd6, 64'h0, 4'h0); tick(); imm_buff_en_i = 1'b0;
      drive(1'b1, 8'd3, 64'h600, 4'd11); tick();
      drive(1'b1, 8'd3, 64'h700, 4'd12); tick();
      drive(1'b0, 8'd3, 64'h0, 4'h0); flush_i = 1'b1; tick(); flush_i = 1'b0; #1;
      chk("fl_valid", valid_o, 0);
      imm_buff_sel_i = 1'b1; drive(1'b1, 8'd0, 64'h800, 4'd13); #1;
      chk("fl_byp_valid", valid_o, 1); chk("fl_byp_data", data_o, 64'h800);
      chk("fl_byp_ready", ready_o, 1); tick();
      imm_buff_sel_i = 1'b0; drive(1'b1, 8'd1, 64'h900, 4'd14); #1;
      chk("fl_new_ready", ready_o, 1); tick();
      drive(1'b0, 8'd3, 64'h0, 4'h0); #1;
      chk("fl_new_data", data_o, 64'h901); chk("fl_new_tag", tag_o, 14); tick();
      for (int i = 0; i < 3; i++) begin
         #1; chk("fl_no_ghost", valid_o, 0); tick();
      end

      // Reset asserted mid-cycle acts only at the next edge
      imm_buff_en_i = 1'b1; drive(1'b1, 8'd3, 64'hA00, 4'd15); tick(); imm_buff_en_i = 1'b0;
      drive(1'b0, 8'd1, 64'h0, 4'h0); #3; rst_ni = 1'b0; #1;
      chk("rstm_ready_hold", ready_o, 0);
      tick(); #1;
      chk("rstm_ready_clr", ready_o, 1); chk("rstm_valid_clr", valid_o, 0);
      rst_ni = 1'b1; imm_buff_sel_i = 1'b1; drive(1'b1, 8'd0, 64'hB00, 4'd0); #1;
      chk("rstm_immq_byp_valid", valid_o, 1); chk("rstm_immq_byp_data", data_o, 64'hB00);
      tick();
      imm_buff_sel_i = 1'b0; drive(1'b0, 8'd3, 64'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         #1; chk("rstm_no_ghost", valid_o, 0); tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end
endmodule
